// File: rtl/stdout_hex_uart.sv
// stdout_hex_uart: prints each accepted 16-bit stdout word as 4 uppercase hex chars plus EOL on an 8N1 UART
module stdout_hex_uart #(
   parameter int CLKS_PER_BIT = 868,
   parameter bit EOL_CRLF     = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_n,
   input  logic        stdout_val_i,
   input  logic [15:0] stdout_data_i,
   output logic        stdout_rdy_o,
   output logic        uart_tx_o,
   output logic        busy_o
);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
   localparam logic [2:0] LAST_CHAR = EOL_CRLF ? 3'd5 : 3'd4;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d, char_q, char_d;
   logic [15:0]   word_q;
   logic          tick, accept, tx_d;
   logic [7:0]    cur_char;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
   endfunction

   function automatic logic [7:0] char_of(input logic [15:0] w, input logic [2:0] i);
      return (i == 3'd0) ? hex_ascii(w[15:12]) :
             (i == 3'd1) ? hex_ascii(w[11:8])  :
             (i == 3'd2) ? hex_ascii(w[7:4])   :
             (i == 3'd3) ? hex_ascii(w[3:0])   :
             (i == LAST_CHAR) ? 8'h0A : 8'h0D;
   endfunction

   assign stdout_rdy_o = (state_q == IDLE);
   assign busy_o       = ~stdout_rdy_o;

   // next-state, counters and the registered tx value for the coming cycle
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      char_d   = char_q;
      tick     = (baud_q == BAUD_MAX);
      accept   = (state_q == IDLE) && stdout_val_i;
      if (state_q != IDLE) baud_d = tick ? '0 : baud_q + BW'(1);
      case (state_q)
         IDLE: if (accept) begin
            state_d = START;
            baud_d  = '0;
            bit_d   = '0;
            char_d  = '0;
         end
         START: if (tick) begin
            state_d = DATA;
            bit_d   = '0;
         end
         DATA: if (tick) begin
            state_d = (bit_q == 3'd7) ? STOP : DATA;
            bit_d   = bit_q + 3'd1;
         end
         STOP: if (tick) begin
            state_d = (char_q == LAST_CHAR) ? IDLE : START;
            char_d  = (char_q == LAST_CHAR) ? char_q : char_q + 3'd1;
         end
         default: state_d = IDLE;
      endcase
      cur_char = char_of(word_q, char_d);
      tx_d     = (state_d == START) ? 1'b0 : (state_d == DATA) ? cur_char[bit_d] : 1'b1;
   end

   // state, counters and the tx flop; reset drops any partial word
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         bit_q     <= '0;
         char_q    <= '0;
         uart_tx_o <= 1'b1;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         char_q    <= char_d;
         uart_tx_o <= tx_d;
      end
   end

   // word register, loaded only at the accepting edge
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) word_q <= '0;
      else if (accept) word_q <= stdout_data_i;
   end
endmodule

// File: tb/tb_stdout_hex_uart.sv
// tb_stdout_hex_uart: randomized self-checking bench with a timing/character reference model
module tb_stdout_hex_uart;
   localparam int C = 4;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b1;
   logic [1:0]       val   = '0;
   logic [1:0][15:0] data  = '0;
   logic [1:0]       tx, rdy, busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   stdout_hex_uart #(.CLKS_PER_BIT(C), .EOL_CRLF(1'b1)) u_a (
      .clk_i(clk), .rst_n(rst_n), .stdout_val_i(val[0]), .stdout_data_i(data[0]),
      .stdout_rdy_o(rdy[0]), .uart_tx_o(tx[0]), .busy_o(busy[0]));

   stdout_hex_uart #(.CLKS_PER_BIT(C), .EOL_CRLF(1'b0)) u_b (
      .clk_i(clk), .rst_n(rst_n), .stdout_val_i(val[1]), .stdout_data_i(data[1]),
      .stdout_rdy_o(rdy[1]), .uart_tx_o(tx[1]), .busy_o(busy[1]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: time since accept determines every output
   int          rem[2];
   int          t[2];
   int          acc_cnt[2];
   int          exp_wr[2];
   logic [15:0] mword[2];
   logic [7:0]  exp_mem[2][1024];

   function automatic int nch(input int i);
      return (i == 0) ? 6 : 5;
   endfunction

   function automatic logic [7:0] exp_char(input logic [15:0] w, input int idx, input int i);
      int nib;
      if (idx < 4) begin
         nib = int'((w >> (12 - 4 * idx)) & 16'hF);
         return (nib < 10) ? 8'(48 + nib) : 8'(65 + nib - 10);
      end
      return (idx == 4 && i == 0) ? 8'h0D : 8'h0A;
   endfunction

   function automatic logic exp_tx(input int i);
      int         j;
      logic [7:0] b;
      if (rem[i] == 0) return 1'b1;
      j = (t[i] % (10 * C)) / C;
      if (j == 0) return 1'b0;
      if (j == 9) return 1'b1;
      b = exp_char(mword[i], t[i] / (10 * C), i);
      return b[j-1];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            rem[i] <= 0;
            t[i]   <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (rem[i] == 0) begin
               if (val[i]) begin
                  rem[i]     <= nch(i) * 10 * C;
                  t[i]       <= 0;
                  mword[i]   <= data[i];
                  acc_cnt[i] <= acc_cnt[i] + 1;
                  for (int n = 0; n < nch(i); n++)
                     exp_mem[i][(exp_wr[i] + n) % 1024] <= exp_char(data[i], n, i);
                  exp_wr[i]  <= exp_wr[i] + nch(i);
               end
            end else begin
               rem[i] <= rem[i] - 1;
               t[i]   <= t[i] + 1;
            end
         end
      end
   end

   // compare process: per-cycle output check plus UART decode at bit centres
   int             k[2];
   int             exp_rd[2];
   int             log_n[2];
   logic [1:0]     in_frame;
   logic [1:0][7:0] sh;
   logic [7:0]     log_mem[2][1024];

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_frame <= '0;
         for (int i = 0; i < 2; i++) exp_rd[i] <= exp_wr[i];
      end else begin
         for (int i = 0; i < 2; i++) begin
            chk("rdy", 32'(rdy[i]), 32'(rem[i] == 0));
            chk("busy", 32'(busy[i]), 32'(rem[i] != 0));
            chk("tx", 32'(tx[i]), 32'(exp_tx(i)));
            if (!in_frame[i]) begin
               if (!tx[i]) begin
                  in_frame[i] <= 1'b1;
                  k[i]        <= 1;
               end
            end else begin
               k[i] <= k[i] + 1;
               for (int j = 1; j <= 8; j++)
                  if (k[i] == j * C + C / 2) sh[i][j-1] <= tx[i];
               if (k[i] == 9 * C + C / 2) begin
                  in_frame[i] <= 1'b0;
                  chk("stop_bit", 32'(tx[i]), 32'd1);
                  chk("byte_pending", 32'(exp_wr[i] > exp_rd[i]), 32'd1);
                  chk("byte", 32'(sh[i]), 32'(exp_mem[i][exp_rd[i] % 1024]));
                  if (exp_wr[i] > exp_rd[i]) exp_rd[i] <= exp_rd[i] + 1;
                  log_mem[i][log_n[i] % 1024] <= sh[i];
                  log_n[i] <= log_n[i] + 1;
               end
            end
         end
      end
   end

   task automatic tick_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input int i, input logic [15:0] d);
      int c0;
      bit got;
      @(negedge clk);
      val[i]  = 1'b1;
      data[i] = d;
      c0      = acc_cnt[i];
      got     = 1'b0;
      for (int n = 0; n < 2000 && !got; n++) begin
         @(negedge clk);
         got = (acc_cnt[i] != c0);
      end
      val[i] = 1'b0;
      chk("accept", 32'(got), 32'd1);
   endtask

   task automatic wait_idle(input int i);
      for (int n = 0; n < 3000 && rem[i] != 0; n++) @(negedge clk);
      tick_n(2);
   endtask

   task automatic chk_log(input string nm, input int i, input int base, input logic [47:0] bytes, input int n);
      for (int m = 0; m < n; m++)
         chk(nm, 32'(log_mem[i][base + m]), 32'(bytes[8*(n-1-m) +: 8]));
   endtask

   initial begin
      int cnt;
      int c0;
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("reset_tx", 32'(tx[i]), 32'd1);
         chk("reset_rdy", 32'(rdy[i]), 32'd1);
         chk("reset_busy", 32'(busy[i]), 32'd0);
      end
      @(negedge clk);
      #2 rst_n = 1'b1;
      tick_n(3);

      send(0, 16'h1A2F);
      chk("tx_low_after_accept", 32'(tx[0]), 32'd0);
      cnt = 0;
      while (!rdy[0] && cnt < 1000) begin
         cnt++;
         @(negedge clk);
      end
      chk("rdy_low_cycles", cnt, 240);
      tick_n(2);
      chk_log("bytes_1A2F", 0, 0, 48'h3141_3246_0D0A, 6);

      send(0, 16'h0000);
      wait_idle(0);
      send(0, 16'hFFFF);
      wait_idle(0);
      chk_log("bytes_0000", 0, 6, 48'h3030_3030_0D0A, 6);
      chk_log("bytes_FFFF", 0, 12, 48'h4646_4646_0D0A, 6);

      c0 = acc_cnt[0];
      @(negedge clk);
      val[0]  = 1'b1;
      data[0] = 16'hBEEF;
      for (int n = 0; n < 2000 && acc_cnt[0] < c0 + 2; n++) begin
         @(negedge clk);
         data[0] = (rem[0] > 8) ? 16'($urandom) : 16'hBEEF;
      end
      val[0] = 1'b0;
      chk("hold_accepts", acc_cnt[0] - c0, 2);
      wait_idle(0);
      chk_log("bytes_BEEF1", 0, 18, 48'h4245_4546_0D0A, 6);
      chk_log("bytes_BEEF2", 0, 24, 48'h4245_4546_0D0A, 6);

      send(1, 16'h9C05);
      cnt = 0;
      while (busy[1] && cnt < 1000) begin
         cnt++;
         @(negedge clk);
      end
      chk("busy_cycles_lf", cnt, 200);
      tick_n(2);
      chk_log("bytes_9C05", 1, 0, 48'h0039_4330_350A, 5);

      send(0, 16'h1234);
      tick_n(97);
      #1 rst_n = 1'b0;
      #1;
      chk("midreset_tx", 32'(tx[0]), 32'd1);
      chk("midreset_rdy", 32'(rdy[0]), 32'd1);
      chk("midreset_busy", 32'(busy[0]), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      tick_n(3);
      send(0, 16'h0001);
      wait_idle(0);
      chk_log("bytes_partial", 0, 30, 48'h0000_0000_3132, 2);
      chk_log("bytes_0001", 0, 32, 48'h3030_3031_0D0A, 6);

      for (int w = 0; w < 50; w++) begin
         tick_n($urandom_range(0, 6));
         send(0, 16'($urandom));
      end
      for (int w = 0; w < 10; w++) begin
         tick_n($urandom_range(0, 6));
         send(1, 16'($urandom));
      end
      wait_idle(0);
      wait_idle(1);
      tick_n(5);
      chk("drain_a", exp_rd[0], exp_wr[0]);
      chk("drain_b", exp_rd[1], exp_wr[1]);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
